uart_host: RTL and testbench

- Bus initiator that drives the UART peripheral's register interface (data register at addr 0, status register at addr 1) from a client-side streaming interface.
- Buffers outgoing bytes in a TX FIFO and writes them when the transmitter is idle.
- Polls the status register and drains received bytes into an RX FIFO.
- Sits between the CPU/DMA client and the UART peripheral, so firmware never busy-waits on UART status.

---
 rtl/uart_bus_pkg.sv | 18 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_host.sv | 109 ++++++++++
 tb/tb_uart_host.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_bus_pkg.sv
// rtl/uart_bus_pkg.sv - UART register map, status bits and host FSM states
package uart_bus_pkg;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int ST_RXAV  = 0;
  localparam int ST_OVR   = 1;
  localparam int ST_TXACT = 2;

  typedef enum logic [1:0] {
    POLL = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head, power-of-two depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero while empty so the client never sees stale storage.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host.sv
// rtl/uart_host.sv - polls a UART register interface, feeding TX and draining RX FIFOs
module uart_host
  import uart_bus_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_dat,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_dat,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_overrun,
  input  logic       i_clr_overrun,
  output logic [7:0] o_u_dat,
  input  logic [7:0] i_u_dat,
  output logic       o_u_addr,
  output logic       o_u_we,
  output logic       o_u_cyc
);

  state_t     state;
  state_t     next_state;
  logic       act_q;
  logic       ovr_q;
  logic [7:0] u_dat_q;
  logic       poll;
  logic [7:0] tx_head;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_full;
  logic       rx_empty;

  // act_q holds the bus quiet for the first cycle out of reset.
  assign poll       = act_q && (state == POLL);
  assign o_u_cyc    = act_q && (state != GAP);
  assign o_u_we     = (state == WR);
  assign o_u_addr   = poll ? ADDR_STATUS : ADDR_DATA;
  assign o_u_dat    = u_dat_q;
  assign o_tx_ready = act_q && !tx_full;
  assign o_rx_valid = !rx_empty;
  assign o_overrun  = ovr_q;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (i_clk),
    .rst_n (i_reset),
    .push  (i_tx_valid && o_tx_ready),
    .din   (i_tx_dat),
    .pop   (state == WR),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (i_clk),
    .rst_n (i_reset),
    .push  (state == RD),
    .din   (i_u_dat),
    .pop   (i_rx_ready && o_rx_valid),
    .head  (o_rx_dat),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    next_state = state;
    case (state)
      POLL: begin
        if (act_q) begin
          if (i_u_dat[ST_RXAV] && !rx_full) begin
            next_state = RD;
          end else if (!i_u_dat[ST_TXACT] && !tx_empty) begin
            next_state = WR;
          end
        end
      end
      RD:      next_state = POLL;
      WR:      next_state = GAP;
      GAP:     next_state = POLL;
      default: next_state = POLL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= POLL;
      act_q   <= 1'b0;
      ovr_q   <= 1'b0;
      u_dat_q <= 8'h00;
    end else begin
      state <= next_state;
      act_q <= 1'b1;
      // Capture the TX head on the way into WR so o_u_dat is a clean register.
      if (next_state == WR) begin
        u_dat_q <= tx_head;
      end
      if (poll && i_u_dat[ST_OVR]) begin
        ovr_q <= 1'b1;
      end else if (i_clr_overrun) begin
        ovr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_host.sv
// tb/tb_uart_host.sv - directed vector bench for uart_host
module tb_uart_host;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_dat;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_dat;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       clr_overrun;
  logic [7:0] u_dat_out;
  logic [7:0] u_dat_in;
  logic       u_addr;
  logic       u_we;
  logic       u_cyc;

  logic [7:0] st_reg;
  logic [7:0] data_reg;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  st;
    logic [7:0]  ud;
    logic        tv;
    logic [7:0]  td;
    logic        rr;
    logic        cl;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  uart_host #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_tx_dat      (tx_dat),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_dat      (rx_dat),
    .o_rx_valid    (rx_valid),
    .i_rx_ready    (rx_ready),
    .o_overrun     (overrun),
    .i_clr_overrun (clr_overrun),
    .o_u_dat       (u_dat_out),
    .i_u_dat       (u_dat_in),
    .o_u_addr      (u_addr),
    .o_u_we        (u_we),
    .o_u_cyc       (u_cyc)
  );

  // UART register model: status at addr 1, data at addr 0.
  always_comb u_dat_in = u_addr ? st_reg : data_reg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] outs();
    return {u_cyc, u_we, u_addr, u_dat_out, tx_ready, rx_valid, rx_dat, overrun};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic [7:0] st, input logic [7:0] ud, input logic tv, input logic [7:0] td,
                   input logic rr, input logic cl, input logic cyc, input logic we, input logic addr,
                   input logic [7:0] udat, input logic txr, input logic rxv, input logic [7:0] rxd,
                   input logic ovr);
    vec_t r;
    r.st = st; r.ud = ud; r.tv = tv; r.td = td; r.rr = rr; r.cl = cl;
    r.exp = {cyc, we, addr, udat, txr, rxv, rxd, ovr};
    vecs.push_back(r);
  endtask

  initial begin
    //  st     ud     tv  td     rr  cl  cyc we ad udat   txr rxv rxd    ovr
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h00, 1, 0, 8'h00, 0); // idle poll
    v(8'h00, 8'h00, 1, 8'h55, 0, 0, 1, 0, 1, 8'h00, 1, 0, 8'h00, 0); // push 55 (N)
    v(8'h00, 8'h00, 1, 8'hAA, 0, 0, 1, 0, 1, 8'h00, 1, 0, 8'h00, 0); // push AA, poll sees data
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 8'h55, 1, 0, 8'h00, 0); // WR 55 at N+2
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h55, 1, 0, 8'h00, 0); // GAP
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h55, 1, 0, 8'h00, 0); // POLL
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 8'hAA, 1, 0, 8'h00, 0); // WR AA
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'hAA, 1, 0, 8'h00, 0); // GAP
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 0, 8'h00, 0); // POLL, empty
    v(8'h01, 8'h3C, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 0, 8'h00, 0); // rx avail
    v(8'h01, 8'h3C, 0, 8'h00, 0, 0, 1, 0, 0, 8'hAA, 1, 0, 8'h00, 0); // RD 3C
    v(8'h01, 8'h11, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h3C, 0);
    v(8'h01, 8'h11, 0, 8'h00, 0, 0, 1, 0, 0, 8'hAA, 1, 1, 8'h3C, 0); // RD 11
    v(8'h01, 8'h22, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h3C, 0);
    v(8'h01, 8'h22, 0, 8'h00, 0, 0, 1, 0, 0, 8'hAA, 1, 1, 8'h3C, 0); // RD 22
    v(8'h01, 8'h33, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h3C, 0);
    v(8'h01, 8'h33, 0, 8'h00, 0, 0, 1, 0, 0, 8'hAA, 1, 1, 8'h3C, 0); // RD 33, now full
    v(8'h01, 8'h44, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h3C, 0); // full: no RD
    v(8'h01, 8'h44, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h3C, 0);
    v(8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h3C, 0); // drain in order
    v(8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h11, 0);
    v(8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h22, 0);
    v(8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h33, 0);
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 0, 8'h00, 0);
    v(8'h04, 8'h00, 1, 8'h77, 0, 0, 1, 0, 1, 8'hAA, 1, 0, 8'h00, 0); // tx active, push 77
    v(8'h05, 8'h99, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 0, 8'h00, 0); // RX wins
    v(8'h05, 8'h99, 0, 8'h00, 0, 0, 1, 0, 0, 8'hAA, 1, 0, 8'h00, 0); // RD 99
    v(8'h04, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h99, 0); // busy: no WR
    v(8'h04, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h99, 0);
    v(8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1, 8'hAA, 1, 1, 8'h99, 0); // b2 clears
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 8'h77, 1, 0, 8'h00, 0); // WR 77
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h77, 1, 0, 8'h00, 0);
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h77, 1, 0, 8'h00, 0);
    v(8'h02, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h77, 1, 0, 8'h00, 0); // overrun seen
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h77, 1, 0, 8'h00, 1);
    v(8'h02, 8'h00, 0, 8'h00, 0, 1, 1, 0, 1, 8'h77, 1, 0, 8'h00, 1); // set beats clear
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h77, 1, 0, 8'h00, 1);
    v(8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0, 1, 8'h77, 1, 0, 8'h00, 1); // clear alone
    v(8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h77, 1, 0, 8'h00, 0);

    rst_n = 1'b0; tx_dat = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; clr_overrun = 1'b0;
    st_reg = 8'h00; data_reg = 8'h00;

    repeat (2) @(negedge clk);
    check("reset_state", outs(), 22'h0);
    rst_n = 1'b1;
    #1 check("release_quiet", outs(), 22'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      st_reg = vecs[i].st; data_reg = vecs[i].ud;
      tx_valid = vecs[i].tv; tx_dat = vecs[i].td;
      rx_ready = vecs[i].rr; clr_overrun = vecs[i].cl;
      #1 check($sformatf("row%0d", i), outs(), vecs[i].exp);
    end

    // Fill the TX FIFO while the transmitter reports busy, then reset mid-access.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      st_reg = 8'h04; rx_ready = 1'b0; clr_overrun = 1'b0;
      tx_valid = 1'b1; tx_dat = 8'hC1 + 8'(i);
      #1 check($sformatf("fill_ready%0d", i), 22'(tx_ready), 22'h1);
    end
    @(negedge clk);
    tx_dat = 8'hEE;
    #1 check("full_not_ready", {u_cyc, u_addr, tx_ready}, 3'b110);
    tx_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), 22'h0);
    @(negedge clk);
    @(negedge clk);
    st_reg = 8'h00;
    rst_n = 1'b1;
    #1 check("released_not_ready", {u_cyc, tx_ready}, 2'b00);
    @(negedge clk);
    #1 check("ready_after_release", {u_cyc, u_we, u_addr, tx_ready, rx_valid}, 5'b10110);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 check($sformatf("no_wr_after_reset%0d", i), {u_we, tx_ready}, 2'b01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
